// File: rtl/hazard_ctrl_if.sv
// Hazard-controller signal bundle: ID/EX/MEM hazard inputs, pipeline-control
// outputs and event counters. The master drives the pipeline-side inputs.
`default_nettype none

interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_use_rs2_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rd_i;
    logic             br_taken_i;
    logic             mem_req_i;
    logic             mem_ready_i;
    logic             pc_write_o;
    logic             ifid_stall_o;
    logic             ifid_flush_o;
    logic             idex_flush_o;
    logic             freeze_o;
    logic             err_o;
    logic [CNT_W-1:0] lu_cnt_o;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] mw_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs2_i, ex_memread_i, ex_rd_i,
               br_taken_i, mem_req_i, mem_ready_i,
        input  pc_write_o, ifid_stall_o, ifid_flush_o, idex_flush_o,
               freeze_o, err_o, lu_cnt_o, br_cnt_o, mw_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs2_i, ex_memread_i, ex_rd_i,
               br_taken_i, mem_req_i, mem_ready_i,
        output pc_write_o, ifid_stall_o, ifid_flush_o, idex_flush_o,
               freeze_o, err_o, lu_cnt_o, br_cnt_o, mw_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl: load-use / taken-branch / memory-wait hazard controller with
// sticky memory-timeout flag and saturating event counters.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int MEM_TMO = 64
) (
    input  wire logic    clk_i,
    input  wire logic    rst_i,
    hazard_ctrl_if.slave bus
);

    localparam logic [0:0] S_RUN      = 1'b0;
    localparam logic [0:0] S_MEM_WAIT = 1'b1;
    localparam int         TMO_W      = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(MEM_TMO - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [TMO_W-1:0] r_tmo;
    logic             r_err;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mw_cnt;

    logic w_lu;
    logic w_mw;
    logic w_lu_evt;
    logic w_br_evt;
    logic w_pc_write;
    logic w_ifid_stall;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_freeze;

    assign w_lu = bus.ex_memread_i && (bus.ex_rd_i != 5'd0) &&
                  ((bus.ex_rd_i == bus.id_rs1_i) ||
                   (bus.id_use_rs2_i && (bus.ex_rd_i == bus.id_rs2_i)));
    assign w_mw = bus.mem_req_i && !bus.mem_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_RUN;
            r_tmo    <= '0;
            r_err    <= 1'b0;
            r_lu_cnt <= '0;
            r_br_cnt <= '0;
            r_mw_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_MEM_WAIT) begin
                if (r_mw_cnt != '1) r_mw_cnt <= r_mw_cnt + 1'b1;
                if (r_tmo == C_TMO_LAST) r_err <= 1'b1;
                // Timeout counter holds at its last value rather than wrapping.
                if (w_state_next == S_RUN)   r_tmo <= '0;
                else if (r_tmo != C_TMO_LAST) r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end
            if (w_lu_evt && (r_lu_cnt != '1)) r_lu_cnt <= r_lu_cnt + 1'b1;
            if (w_br_evt && (r_br_cnt != '1)) r_br_cnt <= r_br_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:      if (w_mw) w_state_next = S_MEM_WAIT;
            S_MEM_WAIT: if (bus.mem_ready_i) w_state_next = S_RUN;
            default:    w_state_next = S_RUN;
        endcase
    end

    // Hazard priority inside RUN: memory wait, then load-use, then branch.
    always_comb begin
        w_pc_write   = 1'b1;
        w_ifid_stall = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_freeze     = 1'b0;
        w_lu_evt     = 1'b0;
        w_br_evt     = 1'b0;
        if (r_state == S_MEM_WAIT || w_mw) begin
            w_pc_write   = 1'b0;
            w_ifid_stall = 1'b1;
            w_freeze     = 1'b1;
        end else if (w_lu) begin
            w_pc_write   = 1'b0;
            w_ifid_stall = 1'b1;
            w_idex_flush = 1'b1;
            w_lu_evt     = 1'b1;
        end else if (bus.br_taken_i) begin
            w_ifid_flush = 1'b1;
            w_br_evt     = 1'b1;
        end
    end

    assign bus.pc_write_o   = w_pc_write;
    assign bus.ifid_stall_o = w_ifid_stall;
    assign bus.ifid_flush_o = w_ifid_flush;
    assign bus.idex_flush_o = w_idex_flush;
    assign bus.freeze_o     = w_freeze;
    assign bus.err_o        = r_err;
    assign bus.lu_cnt_o     = r_lu_cnt;
    assign bus.br_cnt_o     = r_br_cnt;
    assign bus.mw_cnt_o     = r_mw_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by
// random traffic, checked against a rule-level reference model.
`default_nettype none

module tb_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int MEM_TMO = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic pc, stall, flush, idex, freeze, err;
        int   lu, br, mw;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state
    bit known   = 0;
    bit waiting = 0;
    int waits   = 0;
    bit m_err   = 0;
    int m_lu = 0, m_br = 0, m_mw = 0;

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    function automatic void check(input string name, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
        end
    endfunction

    task automatic step(input bit r, input int rs1, input int rs2, input bit use2,
                        input bit ld, input int rd, input bit br,
                        input bit req, input bit rdy);
        exp_t e;
        bit lu, mw;
        @(posedge clk);
        #1;
        rst              = r;
        bus.id_rs1_i     = 5'(rs1);
        bus.id_rs2_i     = 5'(rs2);
        bus.id_use_rs2_i = use2;
        bus.ex_memread_i = ld;
        bus.ex_rd_i      = 5'(rd);
        bus.br_taken_i   = br;
        bus.mem_req_i    = req;
        bus.mem_ready_i  = rdy;
        lu = ld && rd != 0 && (rd == rs1 || (use2 && rd == rs2));
        mw = req && !rdy;
        e = '{pc: 1, stall: 0, flush: 0, idex: 0, freeze: 0, err: m_err,
              lu: m_lu, br: m_br, mw: m_mw};
        if (waiting || mw) begin
            e.pc = 0; e.stall = 1; e.freeze = 1;
        end else if (lu) begin
            e.pc = 0; e.stall = 1; e.idex = 1;
        end else if (br) begin
            e.flush = 1;
        end
        if (known) q.push_back(e);
        if (r) begin
            known = 1; waiting = 0; waits = 0; m_err = 0;
            m_lu = 0; m_br = 0; m_mw = 0;
        end else if (waiting) begin
            waits++;
            m_mw = sat_inc(m_mw);
            if (waits >= MEM_TMO) m_err = 1;
            if (rdy) begin waiting = 0; waits = 0; end
        end else if (mw) begin
            waiting = 1; waits = 0;
        end else if (lu) begin
            m_lu = sat_inc(m_lu);
        end else if (br) begin
            m_br = sat_inc(m_br);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pc_write",   bus.pc_write_o,   e.pc);
                check("ifid_stall", bus.ifid_stall_o, e.stall);
                check("ifid_flush", bus.ifid_flush_o, e.flush);
                check("idex_flush", bus.idex_flush_o, e.idex);
                check("freeze",     bus.freeze_o,     e.freeze);
                check("err",        bus.err_o,        e.err);
                check("lu_cnt",     bus.lu_cnt_o,     e.lu);
                check("br_cnt",     bus.br_cnt_o,     e.br);
                check("mw_cnt",     bus.mw_cnt_o,     e.mw);
            end
        end
    end

    initial begin : stimulus
        bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.id_use_rs2_i = 1'b0;
        bus.ex_memread_i = 1'b0; bus.ex_rd_i = '0; bus.br_taken_i = 1'b0;
        bus.mem_req_i = 1'b0; bus.mem_ready_i = 1'b0;

        // Reset, then observe idle defaults
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Load-use on rs1
        step(0, 5, 0, 0, 1, 5, 0, 0, 0);
        idle(1);
        // rd==0 and unused rs2 match: no stall
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 5, 0, 1, 5, 0, 0, 0);
        step(0, 1, 5, 1, 1, 5, 0, 0, 0);
        // Branch with load-use, then branch alone
        step(0, 7, 0, 0, 1, 7, 1, 0, 0);
        step(0, 7, 0, 0, 0, 7, 1, 0, 0);
        idle(1);
        // Three-cycle memory wait
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);
        // Timeout: err raised after the MEM_TMO-th wait cycle, sticky
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 3, 0, 0, 1, 3, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Reset while waiting abandons the access
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        // Random traffic; small counters saturate along the way
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                 ($urandom_range(0, 9) < 4), $urandom_range(0, 3),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 4));
        end
        idle(1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
